agc_loop_param: RTL and testbench
=================================

// Module: agc_loop_param
// PURPOSE
//  Closed-loop automatic gain control for one complex I/Q stream. Applies a fixed-point gain
//  with symmetric saturation and measures the mean L1 magnitude (|I|+|Q|) of the output over
//  2^LOG2_WIN valid samples. Steps the gain towards a target level with hysteresis, then
//  waits for the loop to settle. Sits between ADC sample capture and the downstream DSP chain.
//  A manual mode bypasses the loop.
// PARAMETERS
//  DATA_W     16    I/Q sample width, signed two's complement
//  GAIN_W     12    gain width, unsigned, FRAC fractional bits
//  FRAC        8    gain fractional bits (gain 2^FRAC = unity)
//  LOG2_WIN    6    log2 of measurement window, in valid samples
//  SETTLE     16    valid samples ignored after each gain change
//  TARGET   8192    target mean |I|+|Q| of output
//  HYST     1024    dead band: no change while |mean-TARGET| <= HYST
//  STEP       16    gain increment/decrement per decision
//  GAIN_MIN   16    lower gain clamp
//  GAIN_MAX 4095    upper gain clamp
//  GAIN_INIT 256    gain after reset
// PORTS
//  clk          in   1        clock
//  arst         in   1        async reset, active low
//  in_valid     in   1        input sample strobe
//  in_I, in_Q   in   DATA_W   input samples, signed
//  agc_en       in   1        1: closed loop; 0: manual gain
//  manual_gain  in   GAIN_W   gain used while agc_en=0
//  out_valid    out  1        output strobe
//  out_I, out_Q out  DATA_W   gained, saturated samples, signed
//  sat          out  1        1 when out_I or out_Q clipped on this out_valid
//  gain         out  GAIN_W   gain currently applied
//  locked       out  1        last decision fell inside the dead band
// BEHAVIOUR
//  Reset (arst=0, async): out_valid=0, out_I=out_Q=0, sat=0, gain=GAIN_INIT, locked=0,
//   FSM=MEASURE, accumulator=0, counters=0.
//  Datapath: prod = in_x * $signed({1'b0,gain}), full width DATA_W+GAIN_W+1. Then
//   sh = prod >>> FRAC (arithmetic). Clamp sh to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
//   Never truncate. Registered: out_* and out_valid appear 1 cycle after in_valid.
//   out_* hold their value while out_valid=0. sat is valid only with out_valid.
//  Gain used for a sample is the gain register value on the cycle in_valid is high.
//  Magnitude: |x| in DATA_W unsigned bits (|-2^(DATA_W-1)| is representable).
//   m = |out_I|+|out_Q|, accumulated on out_valid only. mean = acc >> LOG2_WIN.
//  FSM (states advance on out_valid samples only):
//   MEASURE: acc += m, cnt++. When the 2^LOG2_WIN-th sample is added -> DECIDE.
//   DECIDE (1 cycle): if mean > TARGET+HYST, gain = max(gain-STEP, GAIN_MIN), locked=0.
//    Elif mean < TARGET-HYST, gain = min(gain+STEP, GAIN_MAX), locked=0.
//    Else gain unchanged, locked=1. Compute the clamp without wrap in GAIN_W+1 bits.
//    Gain changed -> SETTLE; gain unchanged -> MEASURE. acc and cnt are cleared.
//    An out_valid in the DECIDE cycle is dropped from measurement.
//   SETTLE: count SETTLE valid samples, then -> MEASURE.
//  agc_en=0: gain <= manual_gain every cycle. FSM held in MEASURE with acc=cnt=0, locked=0.
//   On agc_en 0->1 the loop starts from the last manual_gain with a fresh window.
//  Gain at GAIN_MAX with low input: stays at GAIN_MAX and is not locked. Same at GAIN_MIN.
//  in_valid gaps: no state change except the registered output path.
// TESTING
//  Reset: hold arst=0 with in_valid toggling -> all outputs at reset values, gain=256.
//   Release -> first out_valid 1 cycle after the first in_valid.
//  Manual saturation: agc_en=0, manual_gain=4095. I=20000 -> out_I=32767, sat=1.
//   I=-20000 -> out_I=-32768, sat=1. I=100,Q=-100 -> 1599/-1600, sat=0.
//  Ramp up: agc_en=1, constant I=1000,Q=0 -> gain +16 per window, settles at 1840.
//   out_I=7187, locked=1, no further change.
//  Ramp down: constant I=Q=30000 from gain 256 (sat=1 initially) -> gain decreases.
//   Stops at the first gain with mean <= 9216. Gain never below 16.
//  Clamp: I=Q=0 -> gain climbs to 4095 and stays there, locked=0, no wrap to 0.
//  Reset mid-window: assert arst during MEASURE -> gain=256, acc cleared.
//   After release the first decision is made after exactly 64 valid samples.

Source files
------------

// File: rtl/agc_loop_param.sv
// rtl/agc_loop_param.sv - closed-loop I/Q automatic gain control with saturation and hysteresis
// Gain is stepped once per measurement window, then the loop ignores SETTLE samples.
module agc_loop_param #(
  parameter int DATA_W    = 16,
  parameter int GAIN_W    = 12,
  parameter int FRAC      = 8,
  parameter int LOG2_WIN  = 6,
  parameter int SETTLE    = 16,
  parameter int TARGET    = 8192,
  parameter int HYST      = 1024,
  parameter int STEP      = 16,
  parameter int GAIN_MIN  = 16,
  parameter int GAIN_MAX  = 4095,
  parameter int GAIN_INIT = 256
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_I,
  input  logic signed [DATA_W-1:0] in_Q,
  input  logic                     agc_en,
  input  logic        [GAIN_W-1:0] manual_gain,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_I,
  output logic signed [DATA_W-1:0] out_Q,
  output logic                     sat,
  output logic        [GAIN_W-1:0] gain,
  output logic                     locked
);

  localparam int PW     = DATA_W + GAIN_W + 1;
  localparam int AW     = DATA_W + 1 + LOG2_WIN;
  localparam int WIN    = 1 << LOG2_WIN;
  localparam int CMAX   = (WIN > SETTLE) ? WIN : SETTLE;
  localparam int CW     = $clog2(CMAX + 1);
  localparam int GX     = GAIN_W + 1;
  localparam int SMAX_I = (1 << (DATA_W - 1)) - 1;
  localparam int HI     = TARGET + HYST;
  localparam int LO     = TARGET - HYST;

  localparam logic signed [PW-1:0] SMAX   = PW'(SMAX_I);
  localparam logic signed [PW-1:0] SMIN   = PW'(-SMAX_I - 1);
  localparam logic        [GX-1:0] STEP_X = GX'(STEP);
  localparam logic        [GX-1:0] MIN_X  = GX'(GAIN_MIN);
  localparam logic        [GX-1:0] MAX_X  = GX'(GAIN_MAX);
  localparam logic        [CW-1:0] WIN_LAST    = CW'(WIN - 1);
  localparam logic        [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {ST_MEASURE, ST_DECIDE, ST_SETTLE} state_t;

  state_t            state;
  logic [AW-1:0]     acc;
  logic [CW-1:0]     cnt;
  logic [DATA_W:0]   sc_i, sc_q;
  logic [DATA_W:0]   mag_sum;
  int                mean_i;
  logic [GX-1:0]     g_ext, g_up, g_up_c, g_dn_c;
  logic [GAIN_W-1:0] dec_gain;
  logic              dec_lock;

  // Returns {clipped, saturated result}; product is kept full width so nothing wraps.
  function automatic logic [DATA_W:0] scale(input logic signed [DATA_W-1:0] x,
                                            input logic        [GAIN_W-1:0] g);
    logic signed [PW-1:0] p;
    p = PW'(x) * PW'($signed({1'b0, g}));
    p = p >>> FRAC;
    if (p > SMAX)      scale = {1'b1, SMAX[DATA_W-1:0]};
    else if (p < SMIN) scale = {1'b1, SMIN[DATA_W-1:0]};
    else               scale = {1'b0, p[DATA_W-1:0]};
  endfunction

  function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] x);
    mag = x[DATA_W-1] ? (~x + 1'b1) : x;
  endfunction

  always_comb begin
    sc_i    = scale(in_I, gain);
    sc_q    = scale(in_Q, gain);
    mag_sum = {1'b0, mag(out_I)} + {1'b0, mag(out_Q)};
    mean_i  = int'(acc[AW-1:LOG2_WIN]);
  end

  // Step arithmetic is one bit wider than the gain so the clamps see overflow/underflow.
  always_comb begin
    g_ext    = {1'b0, gain};
    g_up     = g_ext + STEP_X;
    g_up_c   = (g_up > MAX_X) ? MAX_X : g_up;
    g_dn_c   = (g_ext < MIN_X + STEP_X) ? MIN_X : (g_ext - STEP_X);
    dec_gain = gain;
    dec_lock = 1'b0;
    if (mean_i > HI)      dec_gain = g_dn_c[GAIN_W-1:0];
    else if (mean_i < LO) dec_gain = g_up_c[GAIN_W-1:0];
    else                  dec_lock = 1'b1;
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      out_valid <= 1'b0;
      out_I     <= '0;
      out_Q     <= '0;
      sat       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_I <= sc_i[DATA_W-1:0];
        out_Q <= sc_q[DATA_W-1:0];
        sat   <= sc_i[DATA_W] | sc_q[DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      gain   <= GAIN_W'(GAIN_INIT);
      locked <= 1'b0;
      state  <= ST_MEASURE;
      acc    <= '0;
      cnt    <= '0;
    end else if (!agc_en) begin
      gain   <= manual_gain;
      locked <= 1'b0;
      state  <= ST_MEASURE;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        ST_MEASURE: if (out_valid) begin
          acc <= acc + AW'(mag_sum);
          if (cnt == WIN_LAST) begin
            cnt   <= '0;
            state <= ST_DECIDE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // Any out_valid landing in this cycle is deliberately not measured.
        ST_DECIDE: begin
          gain   <= dec_gain;
          locked <= dec_lock;
          acc    <= '0;
          cnt    <= '0;
          state  <= (dec_gain != gain) ? ST_SETTLE : ST_MEASURE;
        end
        ST_SETTLE: if (out_valid) begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= ST_MEASURE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_MEASURE;
      endcase
    end
  end

endmodule

// File: tb/tb_agc_loop_param.sv
// tb/tb_agc_loop_param.sv - randomized and directed check of agc_loop_param against a sample-level model
module tb_agc_loop_param;

  logic               clk = 1'b0;
  logic               arst;
  logic               in_valid;
  logic signed [15:0] in_I, in_Q;
  logic               agc_en;
  logic        [11:0] manual_gain;
  logic               out_valid;
  logic signed [15:0] out_I, out_Q;
  logic               sat;
  logic        [11:0] gain;
  logic               locked;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  agc_loop_param dut (
    .clk(clk), .arst(arst), .in_valid(in_valid), .in_I(in_I), .in_Q(in_Q),
    .agc_en(agc_en), .manual_gain(manual_gain), .out_valid(out_valid),
    .out_I(out_I), .out_Q(out_Q), .sat(sat), .gain(gain), .locked(locked)
  );

  // Reference: outputs are floor(x*g/256) clamped; loop decisions from the mean of a 64-entry window.
  bit m_ov, m_sat, m_locked;
  int m_oi, m_oq, m_gain, m_phase, m_scnt;
  int win[$];

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int scale_ref(input int x, input int g, output bit clip);
    longint p;
    p = (longint'(x) * g) >>> 8;
    clip = 1'b0;
    if (p > 32767)       begin p = 32767;  clip = 1'b1; end
    else if (p < -32768) begin p = -32768; clip = 1'b1; end
    return int'(p);
  endfunction

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic model_reset();
    m_ov = 0; m_oi = 0; m_oq = 0; m_sat = 0;
    m_gain = 256; m_locked = 0; m_phase = 0; m_scnt = 0;
    win.delete();
  endtask

  task automatic model_clock();
    bit pov, ci, cq;
    int poi, poq, sum, mean, ng;
    pov = m_ov; poi = m_oi; poq = m_oq;
    if (in_valid) begin
      m_oi  = scale_ref(int'(in_I), m_gain, ci);
      m_oq  = scale_ref(int'(in_Q), m_gain, cq);
      m_sat = ci | cq;
    end
    m_ov = in_valid;
    if (!agc_en) begin
      m_gain = int'(manual_gain); m_locked = 0; m_phase = 0; m_scnt = 0;
      win.delete();
    end else if (m_phase == 0) begin
      if (pov) begin
        win.push_back(iabs(poi) + iabs(poq));
        if (win.size() == 64) m_phase = 1;
      end
    end else if (m_phase == 1) begin
      sum = 0;
      foreach (win[k]) sum += win[k];
      mean = sum / 64;
      ng = m_gain;
      m_locked = 0;
      if (mean > 9216)      ng = (m_gain - 16 < 16) ? 16 : m_gain - 16;
      else if (mean < 7168) ng = (m_gain + 16 > 4095) ? 4095 : m_gain + 16;
      else                  m_locked = 1;
      win.delete();
      m_phase = (ng != m_gain) ? 2 : 0;
      m_scnt = 0;
      m_gain = ng;
    end else begin
      if (pov) begin
        m_scnt++;
        if (m_scnt == 16) m_phase = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("out_valid", out_valid, m_ov);
    chk("out_I", out_I, m_oi);
    chk("out_Q", out_Q, m_oq);
    if (m_ov) chk("sat", sat, m_sat);
    chk("gain", gain, m_gain);
    chk("locked", locked, m_locked);
  endtask

  task automatic cyc(input bit v, input int i, input int q);
    in_valid = v;
    in_I = 16'(i);
    in_Q = 16'(q);
    @(posedge clk);
    if (arst) model_clock();
    #1 check_all();
  endtask

  task automatic do_reset();
    arst = 1'b0;
    model_reset();
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    arst = 1'b1;
  endtask

  initial begin
    bit reached;
    int amp, lo_gain;
    arst = 1'b0; in_valid = 0; in_I = 0; in_Q = 0; agc_en = 1'b1; manual_gain = 12'd0;
    model_reset();

    // Reset held with in_valid toggling.
    for (int k = 0; k < 6; k++) cyc(k[0], 5000, -5000);
    chk("reset_gain", gain, 256);
    chk("reset_out_valid", out_valid, 0);
    arst = 1'b1;
    cyc(0, 0, 0);
    chk("pre_first_valid", out_valid, 0);
    cyc(1, 300, 400);
    chk("first_out_valid", out_valid, 1);
    chk("first_out_I", out_I, 300);

    // Manual gain saturation.
    agc_en = 1'b0; manual_gain = 12'd4095;
    cyc(0, 0, 0);
    cyc(1, 20000, 0);
    chk("man_pos_sat_I", out_I, 32767);
    chk("man_pos_sat", sat, 1);
    cyc(1, -20000, 0);
    chk("man_neg_sat_I", out_I, -32768);
    chk("man_neg_sat", sat, 1);
    cyc(1, 100, -100);
    chk("man_small_I", out_I, 1599);
    chk("man_small_Q", out_Q, -1600);
    chk("man_small_sat", sat, 0);

    // Random manual gains.
    for (int k = 0; k < 200; k++) begin
      manual_gain = 12'($urandom);
      cyc($urandom_range(3) != 0, int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768);
    end

    // Random closed loop with gaps and occasional mode toggles.
    agc_en = 1'b1;
    amp = 3000;
    for (int k = 0; k < 2500; k++) begin
      if (k % 500 == 0) amp = (k / 500 == 1) ? 200 : (k / 500 == 3) ? 32767 : 3000;
      if ($urandom_range(199) == 0) agc_en = ~agc_en;
      manual_gain = 12'($urandom_range(4095));
      cyc($urandom_range(3) != 0, int'($urandom_range(2 * amp)) - amp, int'($urandom_range(2 * amp)) - amp);
    end
    agc_en = 1'b1;

    // Ramp up to lock at 1840.
    do_reset();
    reached = 0;
    for (int k = 0; k < 12000 && !reached; k++) begin
      cyc(1, 1000, 0);
      reached = (gain == 12'd1840) && locked;
    end
    chk("ramp_up_reached", reached, 1);
    for (int k = 0; k < 300; k++) cyc(1, 1000, 0);
    chk("ramp_up_gain", gain, 1840);
    chk("ramp_up_out_I", out_I, 7187);
    chk("ramp_up_locked", locked, 1);

    // Ramp down from unity; first in-band gain is 32.
    do_reset();
    reached = 0;
    lo_gain = 4096;
    for (int k = 0; k < 3000 && !reached; k++) begin
      cyc(1, 30000, 30000);
      if (int'(gain) < lo_gain) lo_gain = int'(gain);
      reached = (gain == 12'd32) && locked;
    end
    chk("ramp_down_reached", reached, 1);
    chk("ramp_down_min_gain", lo_gain, 32);

    // Zero input drives gain to the upper clamp without wrapping.
    do_reset();
    reached = 0;
    for (int k = 0; k < 25000 && !reached; k++) begin
      cyc(1, 0, 0);
      reached = (gain == 12'd4095);
    end
    chk("clamp_reached", reached, 1);
    lo_gain = 4096;
    for (int k = 0; k < 400; k++) begin
      cyc(1, 0, 0);
      if (int'(gain) < lo_gain) lo_gain = int'(gain);
    end
    chk("clamp_hold_min", lo_gain, 4095);
    chk("clamp_locked", locked, 0);

    // Reset mid-window, then exactly 64 samples to the first decision.
    do_reset();
    for (int k = 0; k < 30; k++) cyc(1, 1000, 0);
    #2 arst = 1'b0;
    model_reset();
    #1;
    chk("midrst_gain", gain, 256);
    chk("midrst_out_valid", out_valid, 0);
    cyc(0, 0, 0);
    arst = 1'b1;
    for (int k = 0; k < 64; k++) cyc(1, 1000, 0);
    cyc(0, 0, 0);
    chk("midrst_pre_decide", gain, 256);
    cyc(0, 0, 0);
    chk("midrst_decide", gain, 272);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
